// File: rtl/mul_div_unit_pkg.sv
// Shared types for the HI/LO multiply/divide unit: op encoding, FSM states and
// the magnitude helper used when latching signed operands.
package mul_div_unit_pkg;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5
  } mdiv_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    FIX  = 2'd3
  } mdiv_state_t;

  // 0x80000000 maps to itself, which is the correct unsigned magnitude.
  function automatic logic [31:0] abs32(input logic [31:0] v);
    return v[31] ? -v : v;
  endfunction

endpackage

// File: rtl/mul_div_unit_if.sv
// M-stage request/response bundle between the pipeline and the mul/div unit.
interface mul_div_unit_if
  import mul_div_unit_pkg::*;
#(
  parameter int WIDTH = 32
);

  logic             en;
  logic             kill;
  mdiv_op_t         op;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             busy;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output en, kill, op, src_a, src_b,
    input  busy, hi, lo
  );

  modport slave (
    input  en, kill, op, src_a, src_b,
    output busy, hi, lo
  );

endinterface

// File: rtl/mul_div_unit.sv
// Iterative HI/LO multiply/divide unit: shift-add multiply, restoring divide,
// one bit per cycle on magnitudes, with sign correction in a final FIX cycle.
//   state | meaning
//   IDLE  | waiting; MTHI/MTLO handled here
//   MUL   | shift-add iteration, WIDTH cycles
//   DIV   | restoring-divide iteration, WIDTH cycles
//   FIX   | sign correction and HI/LO write
module mul_div_unit
  import mul_div_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic          clk,
  input  logic          rst,
  mul_div_unit_if.slave bus
);

  localparam int CW = $clog2(WIDTH);

  mdiv_state_t      state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
  logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
  logic [WIDTH-1:0] dsor_q, dsor_d;
  logic             neg_a_q, neg_a_d;
  logic             neg_b_q, neg_b_d;
  mdiv_op_t         op_q, op_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  logic             op_muldiv, op_is_div, op_signed, start;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [WIDTH:0]   sum, rem_sh, diff;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0] quo, rem;

  assign op_muldiv = (bus.op == MD_MULT) || (bus.op == MD_MULTU) ||
                     (bus.op == MD_DIV)  || (bus.op == MD_DIVU);
  assign op_is_div = (bus.op == MD_DIV) || (bus.op == MD_DIVU);
  assign op_signed = (bus.op == MD_MULT) || (bus.op == MD_DIV);
  assign start     = (state_q == IDLE) && bus.en && !bus.kill && op_muldiv;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      dsor_q   <= '0;
      neg_a_q  <= 1'b0;
      neg_b_q  <= 1'b0;
      op_q     <= MD_MULT;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      dsor_q   <= dsor_d;
      neg_a_q  <= neg_a_d;
      neg_b_q  <= neg_b_d;
      op_q     <= op_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (bus.kill) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:     if (start) state_d = op_is_div ? DIV : MUL;
        MUL, DIV: if (cnt_q == '0) state_d = FIX;
        FIX:      state_d = IDLE;
        default:  state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    mag_a = op_signed ? abs32(bus.src_a) : bus.src_a;
    mag_b = op_signed ? abs32(bus.src_b) : bus.src_b;

    sum    = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, dsor_q} : '0);
    rem_sh = {acc_hi_q, acc_lo_q[WIDTH-1]};
    diff   = rem_sh - {1'b0, dsor_q};

    prod = {acc_hi_q, acc_lo_q};
    if (op_q == MD_MULT && (neg_a_q ^ neg_b_q)) prod = -prod;

    // With a zero divisor the remainder ends up equal to |dividend|, so the
    // dividend-sign correction below restores the raw dividend into HI.
    quo = acc_lo_q;
    rem = acc_hi_q;
    if (op_q == MD_DIV) begin
      if (neg_a_q ^ neg_b_q) quo = -quo;
      if (neg_a_q)           rem = -rem;
    end
    if (dsor_q == '0) quo = '1;
  end

  always_comb begin
    cnt_d    = cnt_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    dsor_d   = dsor_q;
    neg_a_d  = neg_a_q;
    neg_b_d  = neg_b_q;
    op_d     = op_q;
    hi_d     = hi_q;
    lo_d     = lo_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          cnt_d    = CW'(WIDTH - 1);
          acc_hi_d = '0;
          acc_lo_d = op_is_div ? mag_a : mag_b;
          dsor_d   = op_is_div ? mag_b : mag_a;
          neg_a_d  = op_signed & bus.src_a[WIDTH-1];
          neg_b_d  = op_signed & bus.src_b[WIDTH-1];
          op_d     = bus.op;
        end else if (bus.en && !bus.kill) begin
          if (bus.op == MD_MTHI) hi_d = bus.src_a;
          if (bus.op == MD_MTLO) lo_d = bus.src_a;
        end
      end
      MUL: begin
        acc_hi_d = sum[WIDTH:1];
        acc_lo_d = {sum[0], acc_lo_q[WIDTH-1:1]};
        if (cnt_q != '0) cnt_d = cnt_q - CW'(1);
      end
      DIV: begin
        if (!diff[WIDTH]) begin
          acc_hi_d = diff[WIDTH-1:0];
          acc_lo_d = {acc_lo_q[WIDTH-2:0], 1'b1};
        end else begin
          acc_hi_d = rem_sh[WIDTH-1:0];
          acc_lo_d = {acc_lo_q[WIDTH-2:0], 1'b0};
        end
        if (cnt_q != '0) cnt_d = cnt_q - CW'(1);
      end
      FIX: begin
        if (!bus.kill) begin
          if (op_q == MD_MULT || op_q == MD_MULTU) begin
            hi_d = prod[2*WIDTH-1:WIDTH];
            lo_d = prod[WIDTH-1:0];
          end else begin
            hi_d = rem;
            lo_d = quo;
          end
        end
      end
      default: ;
    endcase
  end

  assign bus.busy = (state_q != IDLE);
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed and randomized checks of mul_div_unit against a 64-bit arithmetic model.
module tb_mul_div_unit;
  import mul_div_unit_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  logic [31:0] hi_m = '0;
  logic [31:0] lo_m = '0;

  always #5 clk = ~clk;

  mul_div_unit_if #(.WIDTH(32)) bus ();

  mul_div_unit #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always @(posedge clk) begin
    if (!rst) begin
      assert (!(bus.busy && bus.en))
      else begin
        errors++;
        $error("FAIL en_while_busy observed en=1 busy=1 required no overlap");
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic void model(input mdiv_op_t op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] h, output logic [31:0] l);
    longint sa, sb;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    h = '0;
    l = '0;
    case (op)
      MD_MULTU: begin p = {32'b0, a} * {32'b0, b}; h = p[63:32]; l = p[31:0]; end
      MD_MULT:  begin p = 64'(sa * sb);            h = p[63:32]; l = p[31:0]; end
      MD_DIVU:  if (b == 0) begin l = '1; h = a; end else begin l = a / b; h = a % b; end
      MD_DIV:   if (b == 0) begin l = '1; h = a; end
                else begin l = 32'(sa / sb); h = 32'(sa % sb); end
      default: ;
    endcase
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'h1;
      2:       return 32'hFFFFFFFF;
      3:       return 32'h80000000;
      4:       return 32'($urandom_range(0, 255));
      default: return 32'($urandom());
    endcase
  endfunction

  task automatic run_op(input string tag, input mdiv_op_t op, input logic [31:0] a, input logic [31:0] b);
    int n;
    bus.en = 1'b1; bus.op = op; bus.src_a = a; bus.src_b = b;
    @(negedge clk);
    bus.en = 1'b0;
    n = 0;
    while (bus.busy && n < 40) begin
      n++;
      @(negedge clk);
    end
    model(op, a, b, hi_m, lo_m);
    check({tag, "_busy_len"}, 32'(n), 32'd33);
    check({tag, "_hi"}, bus.hi, hi_m);
    check({tag, "_lo"}, bus.lo, lo_m);
  endtask

  task automatic start_and_wait10(input logic [31:0] a, input logic [31:0] b);
    bus.en = 1'b1; bus.op = MD_MULT; bus.src_a = a; bus.src_b = b;
    @(negedge clk);
    bus.en = 1'b0;
    repeat (9) @(negedge clk);
  endtask

  initial begin
    mdiv_op_t rop;
    bus.en = 1'b0; bus.kill = 1'b0; bus.op = MD_MULT; bus.src_a = '0; bus.src_b = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_hi", bus.hi, 32'd0);
    check("rst_lo", bus.lo, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    run_op("multu_max", MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    check("multu_max_hi_c", bus.hi, 32'hFFFFFFFE);
    check("multu_max_lo_c", bus.lo, 32'h00000001);
    run_op("mult_m3x7", MD_MULT, -32'sd3, 32'd7);
    check("mult_m3x7_lo_c", bus.lo, 32'hFFFFFFEB);
    run_op("mult_min2", MD_MULT, 32'h80000000, 32'h80000000);
    check("mult_min2_hi_c", bus.hi, 32'h40000000);
    run_op("div_m7d2", MD_DIV, -32'sd7, 32'd2);
    check("div_m7d2_lo_c", bus.lo, 32'hFFFFFFFD);
    check("div_m7d2_hi_c", bus.hi, 32'hFFFFFFFF);
    run_op("div_ovf", MD_DIV, 32'h80000000, 32'hFFFFFFFF);
    check("div_ovf_lo_c", bus.lo, 32'h80000000);
    check("div_ovf_hi_c", bus.hi, 32'h0);
    run_op("divu_100d7", MD_DIVU, 32'd100, 32'd7);
    check("divu_100d7_lo_c", bus.lo, 32'd14);
    check("divu_100d7_hi_c", bus.hi, 32'd2);
    run_op("divu_5d0", MD_DIVU, 32'd5, 32'd0);
    check("divu_5d0_lo_c", bus.lo, 32'hFFFFFFFF);
    check("divu_5d0_hi_c", bus.hi, 32'd5);
    run_op("div_m9d0", MD_DIV, -32'sd9, 32'd0);

    bus.en = 1'b1; bus.op = MD_MTHI; bus.src_a = 32'h12345678;
    @(negedge clk);
    check("mthi_hi", bus.hi, 32'h12345678);
    check("mthi_busy", 32'(bus.busy), 32'd0);
    bus.op = MD_MTLO; bus.src_a = 32'hCAFEBABE;
    @(negedge clk);
    check("mtlo_lo", bus.lo, 32'hCAFEBABE);
    check("mtlo_busy", 32'(bus.busy), 32'd0);
    bus.kill = 1'b1; bus.src_a = 32'hDEADBEEF;
    @(negedge clk);
    check("kill_mtlo_lo", bus.lo, 32'hCAFEBABE);
    bus.kill = 1'b0; bus.en = 1'b0;
    hi_m = 32'h12345678; lo_m = 32'hCAFEBABE;

    start_and_wait10(32'h00000003, 32'h00000005);
    check("kill_pre_busy", 32'(bus.busy), 32'd1);
    bus.kill = 1'b1;
    @(negedge clk);
    bus.kill = 1'b0;
    check("kill_busy", 32'(bus.busy), 32'd0);
    repeat (35) @(negedge clk);
    check("kill_hi", bus.hi, hi_m);
    check("kill_lo", bus.lo, lo_m);

    start_and_wait10(32'h00000003, 32'h00000005);
    rst = 1'b1;
    @(negedge clk);
    check("rstmid_busy", 32'(bus.busy), 32'd0);
    check("rstmid_hi", bus.hi, 32'd0);
    check("rstmid_lo", bus.lo, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 40; i++) begin
      rop = mdiv_op_t'($urandom_range(0, 3));
      run_op($sformatf("rnd%0d_%s", i, rop.name()), rop, pick(), pick());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
